// File: rtl/dbg_display_pkg.sv
// Shared constants for the debug display: digit count, idle digit select,
// and the active-low seven-segment patterns (bit0=a .. bit6=g, bit7=dp).
`timescale 1ns/1ps
package dbg_display_pkg;

    localparam int NDIGITS = 8;
    localparam logic [7:0] SEL_IDLE  = 8'hFE;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_ZERO  = 8'hC0;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_AUTO   = 1'b1
    } mode_e;

    function automatic logic [7:0] seg_pattern(input logic [3:0] nib);
        case (nib)
            4'h0: seg_pattern = 8'hC0;
            4'h1: seg_pattern = 8'hF9;
            4'h2: seg_pattern = 8'hA4;
            4'h3: seg_pattern = 8'hB0;
            4'h4: seg_pattern = 8'h99;
            4'h5: seg_pattern = 8'h92;
            4'h6: seg_pattern = 8'h82;
            4'h7: seg_pattern = 8'hF8;
            4'h8: seg_pattern = 8'h80;
            4'h9: seg_pattern = 8'h90;
            4'hA: seg_pattern = 8'h88;
            4'hB: seg_pattern = 8'h83;
            4'hC: seg_pattern = 8'hC6;
            4'hD: seg_pattern = 8'hA1;
            4'hE: seg_pattern = 8'h86;
            4'hF: seg_pattern = 8'h8E;
            default: seg_pattern = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/dbg_display_ctrl_seg7.sv
// seg7_hex_dec: combinational hex nibble to active-low segment pattern, dp off.
`timescale 1ns/1ps
module seg7_hex_dec
    import dbg_display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = seg_pattern(i_nibble);
    end

endmodule

// File: rtl/dbg_display_ctrl.sv
// Debug display controller: CPU step-enable divider, manual/auto channel
// select with freeze, and 8-digit multiplexed hex display.
// Optional macro DBG_CH_TAG_EN: digit 7 shows cur_ch instead of data[31:28].
`timescale 1ns/1ps
module dbg_display_ctrl
    import dbg_display_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int STEP_DIV   = 200_000,
    parameter int SCAN_DIV   = 50_000,
    parameter int AUTO_STEPS = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH*32-1:0]       ch_data,
    input  logic [$clog2(NCH)-1:0]  sel,
    input  logic                    auto,
    input  logic                    freeze,
    output logic                    cpu_step,
    output logic [$clog2(NCH)-1:0]  cur_ch,
    output logic [7:0]              o_seg,
    output logic [7:0]              o_sel
);

    localparam int CW = $clog2(NCH);
    localparam int SW = $clog2(STEP_DIV);
    localparam int KW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(AUTO_STEPS + 1);
    localparam int DW = $clog2(NDIGITS);

    logic [SW-1:0] r_step_cnt;
    logic          r_step;
    logic [CW-1:0] r_cur_ch;
    logic [RW-1:0] r_rot_cnt;
    mode_e         r_mode;
    logic [31:0]   r_disp;
    logic [KW-1:0] r_scan_cnt;
    logic [DW-1:0] r_digit;
    logic [7:0]    r_seg;
    logic [7:0]    r_sel;

    logic [CW-1:0] w_sel_clamped;
    logic [DW-1:0] w_next_digit;
    logic [3:0]    w_nibble;
    logic [7:0]    w_seg_next;

    assign cpu_step = r_step;
    assign cur_ch   = r_cur_ch;
    assign o_seg    = r_seg;
    assign o_sel    = r_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_cnt <= '0;
            r_step     <= 1'b0;
        end else if (r_step_cnt == SW'(STEP_DIV - 1)) begin
            r_step_cnt <= '0;
            r_step     <= 1'b1;
        end else begin
            r_step_cnt <= r_step_cnt + 1'b1;
            r_step     <= 1'b0;
        end
    end

    always_comb begin
        w_sel_clamped = sel;
        if (int'(sel) >= NCH) begin
            w_sel_clamped = CW'(NCH - 1);
        end
    end

    // Freeze gates every channel-path register, so it also wins over a
    // rotation advance landing on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur_ch  <= '0;
            r_rot_cnt <= '0;
            r_mode    <= MODE_MANUAL;
            r_disp    <= '0;
        end else if (!freeze) begin
            r_mode <= auto ? MODE_AUTO : MODE_MANUAL;
            r_disp <= ch_data[32*int'(r_cur_ch) +: 32];
            if (!auto) begin
                r_cur_ch  <= w_sel_clamped;
                r_rot_cnt <= '0;
            end else if (r_mode == MODE_MANUAL) begin
                r_rot_cnt <= '0;
            end else if (r_step) begin
                if (r_rot_cnt == RW'(AUTO_STEPS - 1)) begin
                    r_rot_cnt <= '0;
                    r_cur_ch  <= (r_cur_ch == CW'(NCH - 1)) ? '0 : r_cur_ch + 1'b1;
                end else begin
                    r_rot_cnt <= r_rot_cnt + 1'b1;
                end
            end
        end
    end

    assign w_next_digit = r_digit + 1'b1;

    always_comb begin
        w_nibble = r_disp[4*int'(w_next_digit) +: 4];
`ifdef DBG_CH_TAG_EN
        if (w_next_digit == DW'(NDIGITS - 1)) begin
            w_nibble = 4'(r_cur_ch);
        end
`else
`endif
    end

    seg7_hex_dec u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_seg_next)
    );

    // Segment/select registers load only at slot start, latching the nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_sel      <= SEL_IDLE;
            r_seg      <= SEG_ZERO;
        end else if (r_scan_cnt == KW'(SCAN_DIV - 1)) begin
            r_scan_cnt <= '0;
            r_digit    <= w_next_digit;
            r_sel      <= ~(8'h01 << w_next_digit);
            r_seg      <= w_seg_next;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_dbg_display_ctrl.sv
// Scoreboard bench for dbg_display_ctrl: a time-indexed reference model
// queues expected outputs, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dbg_display_ctrl;

    localparam int NCH        = 4;
    localparam int STEP_DIV   = 4;
    localparam int SCAN_DIV   = 2;
    localparam int AUTO_STEPS = 2;

    localparam logic [7:0] HEX7 [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                         8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NCH*32-1:0]  ch_data = '0;
    logic [1:0]         sel = '0;
    logic               auto = 1'b0;
    logic               freeze = 1'b0;
    logic               cpu_step;
    logic [1:0]         cur_ch;
    logic [7:0]         o_seg;
    logic [7:0]         o_sel;

    dbg_display_ctrl #(
        .NCH        (NCH),
        .STEP_DIV   (STEP_DIV),
        .SCAN_DIV   (SCAN_DIV),
        .AUTO_STEPS (AUTO_STEPS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_data  (ch_data),
        .sel      (sel),
        .auto     (auto),
        .freeze   (freeze),
        .cpu_step (cpu_step),
        .cur_ch   (cur_ch),
        .o_seg    (o_seg),
        .o_sel    (o_sel)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        logic step;
        int   ch;
    } cyc_exp_t;

    cyc_exp_t    ch_q[$];
    logic [15:0] seg_q[$];

    // Reference model: cycle n = n-th rising edge since reset release.
    int          m_cyc = 0;
    int          m_ch = 0;
    int          m_rot = 0;
    int          old_ch;
    int          digit;
    logic [31:0] m_disp = '0;
    logic [31:0] old_disp;
    logic        m_prev_auto = 1'b0;
    logic        step_prev;
    logic [7:0]  m_last_sel = 8'hFE;
    logic [7:0]  exp_sel;
    logic [3:0]  nib;

    always @(posedge clk) begin
        if (rst) begin
            m_cyc = 0; m_ch = 0; m_rot = 0; m_disp = '0; m_prev_auto = 1'b0;
            if (m_last_sel != 8'hFE) begin
                seg_q.push_back({8'hFE, 8'hC0});
                m_last_sel = 8'hFE;
            end
            ch_q.push_back('{step: 1'b0, ch: 0});
        end else begin
            step_prev = (m_cyc > 0) && (m_cyc % STEP_DIV == 0);
            old_ch    = m_ch;
            old_disp  = m_disp;
            m_cyc++;
            if (!freeze) begin
                m_disp = ch_data[32*old_ch +: 32];
                if (!auto) begin
                    m_ch  = (int'(sel) >= NCH) ? NCH - 1 : int'(sel);
                    m_rot = 0;
                end else if (!m_prev_auto) begin
                    m_rot = 0;
                end else if (step_prev) begin
                    m_rot++;
                    if (m_rot == AUTO_STEPS) begin
                        m_rot = 0;
                        m_ch  = (m_ch + 1) % NCH;
                    end
                end
                m_prev_auto = auto;
            end
            if (m_cyc % SCAN_DIV == 0) begin
                digit = (m_cyc / SCAN_DIV) % 8;
                nib   = old_disp[4*digit +: 4];
`ifdef DBG_CH_TAG_EN
                if (digit == 7) nib = 4'(old_ch);
`endif
                exp_sel = ~(8'h01 << digit);
                seg_q.push_back({exp_sel, HEX7[nib]});
                m_last_sel = exp_sel;
            end
            ch_q.push_back('{step: (m_cyc % STEP_DIV == 0), ch: m_ch});
        end
    end

    logic [7:0]  mon_prev_sel = 8'hFE;
    cyc_exp_t    ce;
    logic [15:0] se;

    always @(negedge clk) begin
        if (ch_q.size() == 0) begin
            chk("cyc_queue_nonempty", ch_q.size(), 1);
        end else begin
            ce = ch_q.pop_front();
            chk("cpu_step", {31'b0, cpu_step}, {31'b0, ce.step});
            chk("cur_ch", {30'b0, cur_ch}, ce.ch);
        end
        if (o_sel !== mon_prev_sel) begin
            if (seg_q.size() == 0) begin
                chk("slot_queue_nonempty", seg_q.size(), 1);
            end else begin
                se = seg_q.pop_front();
                chk("o_sel", {24'b0, o_sel}, {24'b0, se[15:8]});
                chk("o_seg", {24'b0, o_seg}, {24'b0, se[7:0]});
            end
            mon_prev_sel = o_sel;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        #1;
        chk("rst_o_sel", {24'b0, o_sel}, 32'hFE);
        chk("rst_o_seg", {24'b0, o_seg}, 32'hC0);
        chk("rst_cpu_step", {31'b0, cpu_step}, 32'h0);
        chk("rst_cur_ch", {30'b0, cur_ch}, 32'h0);
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        tick(n);
        check_reset_state();
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) ch_data[32*k +: 32] = $urandom;
        repeat (3) @(posedge clk);
        check_reset_state();
        @(posedge clk);
        #2;
        rst = 1'b0;
        tick(12);

        // Manual select of a known word, full scan.
        ch_data[63:32] = 32'h1234_ABCD;
        sel = 2'd1;
        tick(20);

        // Auto rotation starting from channel 3.
        sel = 2'd3;
        tick(3);
        auto = 1'b1;
        tick(24);
        auto = 1'b0;
        tick(4);

        // Freeze holds display across a data change.
        freeze = 1'b1;
        tick(1);
        ch_data = '1;
        tick(20);
        freeze = 1'b0;
        tick(20);

        // Reset landing mid-scan.
        tick(9);
        pulse_reset(1);
        tick(12);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) ch_data[32*$urandom_range(0, NCH - 1) +: 32] = $urandom;
            if ($urandom_range(0, 9) == 0) sel = 2'($urandom);
            if ($urandom_range(0, 39) == 0) auto = ~auto;
            if ($urandom_range(0, 29) == 0) freeze = ~freeze;
            if (i == 777) pulse_reset(2);
            tick(1);
        end

        freeze = 1'b0;
        tick(20);
        @(negedge clk);
        #1;
        chk("slot_queue_drained", seg_q.size(), 0);
        chk("cycle_queue_drained", ch_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
